updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter_pkg.sv | 13 +
 rtl/updown_counter.sv | 87 ++++++++
 tb/tb_updown_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// Shared counter package: default geometry and
// saturation mode encodings.
package updown_counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_MOD   = 16;

  typedef enum logic {
    SAT_WRAP = 1'b0,
    SAT_HOLD = 1'b1
  } sat_mode_e;

endpackage

// File: rtl/updown_counter.sv
// Modulo-MOD up/down counter with load,
// wrap-or-saturate bounds and a wrap pulse.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MOD   = DEF_MOD,
  parameter int SAT   = int'(SAT_WRAP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  // One extra bit so MOD == 2^WIDTH fits.
  localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);
  localparam bit             HOLD = (SAT == int'(SAT_HOLD));

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   cnt_x, lv_x;
  logic             do_load, do_inc, do_dec;

  assign cnt_x   = {1'b0, count_q};
  assign lv_x    = {1'b0, load_val};
  assign do_load = load;
  assign do_inc  = !load && en && up;
  assign do_dec  = !load && en && !up;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (1'b1)
      do_load: begin
        if (lv_x >= MODV)
          count_d = MAXV[WIDTH-1:0];
        else
          count_d = load_val;
      end
      do_inc: begin
        if (cnt_x == MAXV) begin
          wrap_d  = 1'b1;
          count_d = HOLD ? count_q : '0;
        end else begin
          count_d = WIDTH'(cnt_x + ONE);
        end
      end
      do_dec: begin
        if (cnt_x == '0) begin
          wrap_d  = 1'b1;
          count_d = HOLD ? count_q
                         : MAXV[WIDTH-1:0];
        end else begin
          count_d = WIDTH'(cnt_x - ONE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign count_n = ~count_q;
  assign at_max  = (cnt_x == MAXV);
  assign at_min  = (count_q == '0);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter with
// default, wrap-10 and sat-10 instances.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_val;

  logic [3:0] d_cnt, d_cntn, w_cnt, w_cntn;
  logic [3:0] s_cnt, s_cntn;
  logic       d_max, d_min, d_wrap;
  logic       w_max, w_min, w_wrap;
  logic       s_max, s_min, s_wrap;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_counter u_def (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(d_cnt), .count_n(d_cntn),
    .at_max(d_max), .at_min(d_min),
    .wrap(d_wrap)
  );

  updown_counter #(.WIDTH(4), .MOD(10), .SAT(0)) u_w (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(w_cnt), .count_n(w_cntn),
    .at_max(w_max), .at_min(w_min),
    .wrap(w_wrap)
  );

  updown_counter #(.WIDTH(4), .MOD(10), .SAT(1)) u_s (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .load_val(load_val),
    .count(s_cnt), .count_n(s_cntn),
    .at_max(s_max), .at_min(s_min),
    .wrap(s_wrap)
  );

  typedef struct {
    logic       r, ld, e, u;
    logic [3:0] lv;
    logic [3:0] ec;
    logic       ew, emax, emin;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic ld,
                       input logic e,
                       input logic u,
                       input logic [3:0] lv);
    rst = r; load = ld; en = e; up = u;
    load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 4'd0);
    tick();
    drive(0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    drive(1, 0, 0, 0, 4'd0);
    tick();
    tick();
    drive(0, 0, 0, 0, 4'd0);
    tick();
    chk("rst_count", d_cnt, 0);
    chk("rst_count_n", d_cntn, 15);
    chk("rst_at_min", d_min, 1);
    chk("rst_at_max", d_max, 0);
    chk("rst_wrap", d_wrap, 0);

    tbl[0]  = '{0, 1, 0, 0, 4'd14, 4'd14, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 4'd0,  4'd15, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 1, 4'd0,  4'd0,  1, 0, 1};
    tbl[3]  = '{0, 0, 1, 0, 4'd0,  4'd15, 1, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 4'd0,  4'd14, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 4'd0,  4'd14, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 1, 4'd5,  4'd5,  0, 0, 0};
    tbl[7]  = '{1, 1, 1, 1, 4'd9,  4'd0,  0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 4'd3,  4'd3,  0, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 4'd0,  4'd0,  0, 0, 1};
    tbl[10] = '{0, 0, 1, 0, 4'd0,  4'd15, 1, 1, 0};
    tbl[11] = '{1, 0, 1, 0, 4'd0,  4'd0,  0, 0, 1};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].ld, tbl[i].e,
            tbl[i].u, tbl[i].lv);
      tick();
      chk($sformatf("vec%0d_count", i),
          d_cnt, tbl[i].ec);
      chk($sformatf("vec%0d_wrap", i),
          d_wrap, tbl[i].ew);
      chk($sformatf("vec%0d_max", i),
          d_max, tbl[i].emax);
      chk($sformatf("vec%0d_min", i),
          d_min, tbl[i].emin);
      chk($sformatf("vec%0d_cntn", i),
          d_cntn, 15 - int'(tbl[i].ec));
    end

    do_reset();
    drive(0, 0, 1, 1, 4'd0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk($sformatf("run%0d_count", i),
          d_cnt, i % 16);
      chk($sformatf("run%0d_wrap", i),
          d_wrap, (i == 16) ? 1 : 0);
    end

    do_reset();
    drive(0, 0, 1, 0, 4'd0);
    tick();
    chk("m10_dn_count", w_cnt, 9);
    chk("m10_dn_wrap", w_wrap, 1);
    chk("m10_dn_max", w_max, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("m10_dn%0d_count", i),
          w_cnt, 8 - i);
      chk($sformatf("m10_dn%0d_wrap", i),
          w_wrap, 0);
    end
    drive(1, 0, 1, 0, 4'd0);
    tick();
    chk("abort_count", w_cnt, 0);
    chk("abort_wrap", w_wrap, 0);

    drive(0, 1, 0, 0, 4'd12);
    tick();
    chk("sat_load_count", s_cnt, 9);
    chk("sat_load_max", s_max, 1);
    chk("sat_load_wrap", s_wrap, 0);
    chk("wrap_load_clamp", w_cnt, 9);
    drive(0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_up%0d_count", i),
          s_cnt, 9);
      chk($sformatf("sat_up%0d_wrap", i),
          s_wrap, 1);
    end
    drive(0, 0, 0, 0, 4'd0);
    tick();
    chk("sat_idle_wrap", s_wrap, 0);

    drive(0, 1, 0, 0, 4'd0);
    tick();
    drive(0, 0, 1, 0, 4'd0);
    tick();
    chk("sat_min_count", s_cnt, 0);
    chk("sat_min_wrap", s_wrap, 1);

    do_reset();
    drive(0, 0, 1, 1, 4'd0);
    repeat (7) tick();
    chk("tog_base", d_cnt, 7);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2 == 0), 4'd0);
      tick();
      chk($sformatf("tog%0d_count", i),
          d_cnt, (i % 2 == 0) ? 8 : 7);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
